pipe_add_acc: RTL and testbench

Parametrised, pipelined unsigned adder/accumulator with valid/ready handshakes on input and output. It generalises the plain combinational byte adder: WIDTH-bit operands, STAGES-deep registered pipeline with backpressure, and a second mode that sums into a persistent accumulator. It sits between an operand source (pin capture or upstream block) and a result consumer in the tile datapath.

---
 rtl/pipe_add_acc.sv | 122 ++++++++++++
 tb/tb_pipe_add_acc.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_add_acc.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_add_acc
//  Purpose  : Pipelined unsigned adder/accumulator, valid/ready on both sides.
//             Optional saturation enabled by defining PIPE_ADD_ACC_SAT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_add_acc #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    input  logic             in_mode_i,
    input  logic             acc_clr_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_sum_o,
    output logic             out_ovf_o,
    output logic [WIDTH-1:0] acc_value_o
);

    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0][WIDTH-1:0] sum_q,   sum_d;
    logic [STAGES-1:0]            ovf_q,   ovf_d;
    logic [WIDTH-1:0]             acc_q,   acc_d;

    logic [STAGES-1:0] w_free;
    logic              w_accept;
    logic [WIDTH-1:0]  w_opb;
    logic [WIDTH:0]    w_full;
    logic              w_carry;
    logic [WIDTH-1:0]  w_result;

    // A slot is free when it is empty or its content moves on this cycle;
    // the chain runs back from the consumer so in_ready follows out_ready.
    always_comb begin : p_free
        logic l_chain;
        l_chain = out_ready_i;
        w_free  = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            l_chain   = l_chain || !valid_q[i];
            w_free[i] = l_chain;
        end
    end

    assign w_accept   = in_valid_i && w_free[0];
    assign in_ready_o = w_free[0];

    // A clear coinciding with an accumulate beat makes that beat start from zero.
    always_comb begin
        w_opb = in_b_i;
        if (in_mode_i) begin
            w_opb = acc_clr_i ? '0 : acc_q;
        end
    end

    assign w_full  = {1'b0, in_a_i} + {1'b0, w_opb};
    assign w_carry = w_full[WIDTH];

`ifdef PIPE_ADD_ACC_SAT_EN
    assign w_result = w_carry ? '1 : w_full[WIDTH-1:0];
`else
    assign w_result = w_full[WIDTH-1:0];
`endif

    always_comb begin
        acc_d = acc_q;
        if (w_accept && in_mode_i) begin
            acc_d = w_result;
        end else if (acc_clr_i) begin
            acc_d = '0;
        end
    end

    always_comb begin
        valid_d = valid_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        if (w_free[0]) begin
            valid_d[0] = w_accept;
            if (w_accept) begin
                sum_d[0] = w_result;
                ovf_d[0] = w_carry;
            end
        end
        for (int i = 1; i < STAGES; i++) begin
            if (w_free[i]) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    sum_d[i] = sum_q[i-1];
                    ovf_d[i] = ovf_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            sum_q   <= '0;
            ovf_q   <= '0;
            acc_q   <= '0;
        end else begin
            valid_q <= valid_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            acc_q   <= acc_d;
        end
    end

    assign out_valid_o = valid_q[STAGES-1];
    assign out_sum_o   = sum_q[STAGES-1];
    assign out_ovf_o   = ovf_q[STAGES-1];
    assign acc_value_o = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_add_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_add_acc
//  Purpose  : Self-checking bench for pipe_add_acc against a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_add_acc;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;
    localparam int MOD    = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, in_mode, acc_clr;
    logic [WIDTH-1:0] in_a, in_b;
    logic             out_valid, out_ready, out_ovf;
    logic [WIDTH-1:0] out_sum, acc_value;

    pipe_add_acc #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_a_i      (in_a),
        .in_b_i      (in_b),
        .in_mode_i   (in_mode),
        .acc_clr_i   (acc_clr),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_sum_o   (out_sum),
        .out_ovf_o   (out_ovf),
        .acc_value_o (acc_value)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             o;
    } beat_t;

    beat_t            exp_q[$];
    logic [WIDTH-1:0] obs_q[$];
    int               xcyc_q[$];
    int               m_acc;
    int               n_cmp = 0, n_err = 0;
    int               n_acc = 0, n_xfer = 0, cyc = 0;
    logic             hold_pending = 1'b0;
    logic [WIDTH-1:0] hold_sum;
    logic             hold_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference sum of two unsigned values with the configured overflow policy.
    function automatic beat_t ref_sum(input int x, input int y);
        beat_t r;
        int    full;
        full = x + y;
        r.o  = (full >= MOD);
        r.s  = WIDTH'(full % MOD);
`ifdef PIPE_ADD_ACC_SAT_EN
        if (r.o) r.s = WIDTH'(MOD - 1);
`endif
        return r;
    endfunction

    // One clock: observe at the falling edge, update the model, then advance.
    task automatic step();
        beat_t b;
        @(negedge clk);
        cyc++;
        if (hold_pending) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_sum", 32'(out_sum), 32'(hold_sum));
            check("hold_ovf", 32'(out_ovf), 32'(hold_ovf));
        end
        hold_pending = out_valid && !out_ready;
        hold_sum     = out_sum;
        hold_ovf     = out_ovf;
        if (out_valid && out_ready) begin
            n_xfer++;
            obs_q.push_back(out_sum);
            xcyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(out_sum), 32'hDEAD);
            end else begin
                b = exp_q.pop_front();
                check("out_sum", 32'(out_sum), 32'(b.s));
                check("out_ovf", 32'(out_ovf), 32'(b.o));
            end
        end
        check("acc_value", 32'(acc_value), 32'(m_acc));
        if (in_valid && in_ready) begin
            n_acc++;
            if (in_mode) begin
                b     = ref_sum(acc_clr ? 0 : m_acc, int'(in_a));
                m_acc = int'(b.s);
            end else begin
                b = ref_sum(int'(in_a), int'(in_b));
                if (acc_clr) m_acc = 0;
            end
            exp_q.push_back(b);
        end else if (acc_clr) begin
            m_acc = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        in_valid  = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 200) begin
            step();
            k++;
        end
        if (k >= 200) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_out(input string tag, output int edges);
        edges = 0;
        while (!out_valid && edges < 50) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (edges >= 50) check({tag, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic send(input logic mode, input logic clr, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b);
        in_valid = 1'b1; in_mode = mode; acc_clr = clr; in_a = a; in_b = b;
        step();
        in_valid = 1'b0; acc_clr = 1'b0;
    endtask

    initial begin
        int k, base, edges;
        rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; acc_clr = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b1; m_acc = 0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        check("rst_acc", 32'(acc_value), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single add beat: value and latency.
        send(1'b0, 1'b0, 8'h12, 8'h34);
        wait_out("lat", edges);
        check("latency_edges", 32'(edges), 32'(STAGES - 1));
        check("add_0x46", 32'(out_sum), 32'h46);
        check("add_0x46_ovf", 32'(out_ovf), 32'd0);
        drain();

        // Overflow policy.
        send(1'b0, 1'b0, 8'hFF, 8'h02);
        wait_out("ovf", edges);
`ifdef PIPE_ADD_ACC_SAT_EN
        check("ovf_sum", 32'(out_sum), 32'hFF);
`else
        check("ovf_sum", 32'(out_sum), 32'h01);
`endif
        check("ovf_flag", 32'(out_ovf), 32'd1);
        drain();

        // Ten-beat stream at full rate.
        obs_q.delete(); xcyc_q.delete();
        base = n_acc;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_mode = 1'b0;
            in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
            step();
        end
        check("stream_accepts", 32'(n_acc - base), 32'd10);
        drain();
        check("stream_results", 32'(obs_q.size()), 32'd10);
        if (xcyc_q.size() == 10)
            check("stream_span", 32'(xcyc_q[9] - xcyc_q[0]), 32'd9);

        // Accumulate chain, then clear together with an accumulate beat.
        in_valid = 1'b0; acc_clr = 1'b1; step(); acc_clr = 1'b0;
        obs_q.delete();
        in_valid = 1'b1; in_mode = 1'b1;
        in_a = 8'h10; step();
        in_a = 8'h20; step();
        in_a = 8'h30; step();
        in_valid = 1'b0;
        check("acc_chain", 32'(acc_value), 32'h60);
        drain();
        if (obs_q.size() == 3) begin
            check("acc_r0", 32'(obs_q[0]), 32'h10);
            check("acc_r1", 32'(obs_q[1]), 32'h30);
            check("acc_r2", 32'(obs_q[2]), 32'h60);
        end else check("acc_count", 32'(obs_q.size()), 32'd3);
        obs_q.delete();
        send(1'b1, 1'b1, 8'h05, 8'h77);
        check("clr_acc_value", 32'(acc_value), 32'h05);
        drain();
        if (obs_q.size() == 1) check("clr_acc_result", 32'(obs_q[0]), 32'h05);
        else check("clr_acc_count", 32'(obs_q.size()), 32'd1);

        // Backpressure: pipe fills to exactly STAGES beats.
        obs_q.delete();
        base = n_acc;
        out_ready = 1'b0; in_mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
            step();
        end
        check("bp_accepts", 32'(n_acc - base), 32'(STAGES));
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        drain();
        check("bp_delivered", 32'(obs_q.size()), 32'(STAGES));

        // Randomised traffic against the model.
        base = n_acc; k = 0;
        while (n_acc - base < 1000 && k < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_mode   = 1'($urandom);
            acc_clr   = ($urandom_range(0, 15) == 0);
            in_a      = WIDTH'($urandom);
            in_b      = WIDTH'($urandom);
            step();
            k++;
        end
        check("rand_accepts", 32'(n_acc - base >= 1000), 32'd1);
        drain();

        // Reset with a full pipe.
        out_ready = 1'b0; in_mode = 1'b1; acc_clr = 1'b0;
        for (int i = 0; i < STAGES + 2; i++) begin
            in_valid = 1'b1; in_a = WIDTH'($urandom | 1); step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_sum", 32'(out_sum), 32'd0);
        check("mid_rst_acc", 32'(acc_value), 32'd0);
        exp_q.delete(); m_acc = 0; hold_pending = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        base = n_xfer;
        for (int i = 0; i < STAGES + 3; i++) step();
        check("post_rst_no_stale", 32'(n_xfer - base), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
